// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and default widths common to
// the generator and capture cores.
package pwm_pkg;

  typedef enum logic {
    CAP_IDLE,
    CAP_MEASURE
  } cap_state_t;

  localparam int DEF_WIDTH_PERIOD = 16;
  localparam int DEF_WIDTH_DUTY   = 16;

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: input synchroniser, registered edge detect,
// saturating period counter, measurement FSM and result registers.
module pwm_capture_ch
  import pwm_pkg::*;
#(
  parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD,
  parameter int WIDTH_DUTY   = DEF_WIDTH_DUTY,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pwm_in,
  input  logic                    ovf_clear,
  output logic [WIDTH_PERIOD-1:0] period_meas,
  output logic [WIDTH_DUTY-1:0]   duty_meas,
  output logic                    meas_valid,
  output logic                    overflow
);

  localparam logic [WIDTH_PERIOD-1:0] CNT_MAX      = {WIDTH_PERIOD{1'b1}};
  localparam logic [WIDTH_DUTY-1:0]   DUTY_MAX     = {WIDTH_DUTY{1'b1}};
  localparam logic [WIDTH_PERIOD-1:0] DUTY_MAX_CNT = WIDTH_PERIOD'(DUTY_MAX);

  logic [SYNC_STAGES-1:0]  sync_reg;
  logic                    prev_reg;
  logic                    rise_reg;
  logic                    fall_reg;
  logic                    s;

  cap_state_t              state_reg, state_next;
  logic [WIDTH_PERIOD-1:0] cnt_reg, cnt_next;
  logic [WIDTH_DUTY-1:0]   high_lat_reg, high_lat_next;
  logic [WIDTH_PERIOD-1:0] period_reg, period_next;
  logic [WIDTH_DUTY-1:0]   duty_reg, duty_next;
  logic                    valid_reg, valid_next;
  logic                    ovf_reg, ovf_next;
  logic                    ovf_set;

  assign s = sync_reg[SYNC_STAGES-1];

  // Edge flags are registered so the FSM sees a clean one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pwm_in};
      prev_reg <= s;
      rise_reg <= s & ~prev_reg;
      fall_reg <= ~s & prev_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= CAP_IDLE;
      cnt_reg      <= '0;
      high_lat_reg <= '0;
      period_reg   <= '0;
      duty_reg     <= '0;
      valid_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      high_lat_reg <= high_lat_next;
      period_reg   <= period_next;
      duty_reg     <= duty_next;
      valid_reg    <= valid_next;
      ovf_reg      <= ovf_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    high_lat_next = high_lat_reg;
    period_next   = period_reg;
    duty_next     = duty_reg;
    valid_next    = 1'b0;
    ovf_set       = 1'b0;

    if (rise_reg) begin
      cnt_next = WIDTH_PERIOD'(1);
    end else if (cnt_reg == CNT_MAX) begin
      cnt_next = cnt_reg;
    end else begin
      cnt_next = cnt_reg + WIDTH_PERIOD'(1);
    end

    case (state_reg)
      CAP_IDLE: begin
        if (rise_reg) begin
          state_next    = CAP_MEASURE;
          high_lat_next = '0;
        end
      end
      CAP_MEASURE: begin
        if (rise_reg) begin
          period_next   = cnt_reg;
          duty_next     = high_lat_reg;
          valid_next    = 1'b1;
          high_lat_next = '0;
        end else begin
          if (fall_reg) begin
            high_lat_next = (cnt_reg > DUTY_MAX_CNT) ? DUTY_MAX
                                                     : cnt_reg[WIDTH_DUTY-1:0];
          end
          // Saturated without a new rise: stuck input or period out of range.
          if (cnt_reg == CNT_MAX) begin
            ovf_set    = 1'b1;
            state_next = CAP_IDLE;
          end
        end
      end
      default: state_next = CAP_IDLE;
    endcase

    ovf_next = ovf_set | (ovf_reg & ~ovf_clear);
  end

  assign period_meas = period_reg;
  assign duty_meas   = duty_reg;
  assign meas_valid  = valid_reg;
  assign overflow    = ovf_reg;

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM capture: N_CHANNELS independent period/high-time
// measurement channels with results packed channel 0 in the low bits.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int N_CHANNELS   = 4,
  parameter int WIDTH_PERIOD = DEF_WIDTH_PERIOD,
  parameter int WIDTH_DUTY   = DEF_WIDTH_DUTY,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [N_CHANNELS-1:0]              pwm_in,
  input  logic [N_CHANNELS-1:0]              ovf_clear,
  output logic [N_CHANNELS*WIDTH_PERIOD-1:0] period_meas,
  output logic [N_CHANNELS*WIDTH_DUTY-1:0]   duty_meas,
  output logic [N_CHANNELS-1:0]              meas_valid,
  output logic [N_CHANNELS-1:0]              overflow
);

  generate
    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
      pwm_capture_ch #(
        .WIDTH_PERIOD (WIDTH_PERIOD),
        .WIDTH_DUTY   (WIDTH_DUTY),
        .SYNC_STAGES  (SYNC_STAGES)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .pwm_in      (pwm_in[gi]),
        .ovf_clear   (ovf_clear[gi]),
        .period_meas (period_meas[gi*WIDTH_PERIOD +: WIDTH_PERIOD]),
        .duty_meas   (duty_meas[gi*WIDTH_DUTY +: WIDTH_DUTY]),
        .meas_valid  (meas_valid[gi]),
        .overflow    (overflow[gi])
      );
    end
  endgenerate

endmodule
